multi_channel_timer: RTL

Parametrised successor to the single-channel start/capture/alarm timer, with NUM_CH independent channels of CNT_W-bit counters in one clock domain.
- Each channel measures start->capture intervals in clock cycles and supports multiple captures per start.
- Each channel has a per-channel alarm that can be one-shot or periodic; the periodic mode is new.
- Sits beside the existing timer in the timing subsystem and is driven by an extended timer_bfm/tester.

---
 rtl/multi_channel_timer_pkg.sv | 10 +
 rtl/multi_channel_timer_channel.sv | 65 ++++++
 rtl/multi_channel_timer.sv | 43 ++++
 3 files changed

// File: rtl/multi_channel_timer_pkg.sv
// timer_pkg: shared channel state type and index/slice helpers for the multi-channel timer
package timer_pkg;
  typedef enum logic {IDLE, RUN} chan_state_t;
  function automatic int ch_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int slice_lo(input int c, input int w);
    return c * w;
  endfunction
endpackage

// File: rtl/multi_channel_timer_channel.sv
// timer_channel: one start/capture channel with saturating counter, overflow flag and one-shot/periodic alarm
module timer_channel import timer_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic             start,
  input  logic             capture,
  input  logic             rst_capture,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_alarm_time,
  input  logic             cfg_alarm_en,
  input  logic             cfg_periodic,
  output logic             running,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] capture_value,
  output logic             capture_valid,
  output logic             alarm,
  output logic             overflow
);
  localparam logic [CNT_W-1:0] MAX = '1;
  chan_state_t state;
  logic [CNT_W-1:0] alarm_time;
  logic alarm_en, periodic, match, cap_ok;
  assign running = state == RUN;
  assign cap_ok = running && capture && !start && !rst_capture;
  assign match = running && alarm_en && count == alarm_time && !start && !rst_capture;
  always_ff @(posedge clk) begin
    if (sreset) begin
      state <= IDLE;
      count <= '0;
      capture_value <= '0;
      capture_valid <= 1'b0;
      alarm <= 1'b0;
      overflow <= 1'b0;
      alarm_time <= '0;
      alarm_en <= 1'b0;
      periodic <= 1'b0;
    end else begin
      capture_valid <= cap_ok;
      alarm <= match;
      if (cap_ok) capture_value <= count;
      if (rst_capture) begin
        state <= IDLE;
        count <= '0;
        capture_value <= '0;
        overflow <= 1'b0;
      end else if (start) begin
        state <= RUN;
        count <= '0;
        overflow <= 1'b0;
      end else if (running) begin
        if (match && periodic) count <= '0;
        else if (count != MAX) count <= count + CNT_W'(1);
        if (!(match && periodic) && count == MAX - CNT_W'(1)) overflow <= 1'b1;
        if (match && !periodic) alarm_en <= 1'b0;
      end
      if (cfg_we) begin
        alarm_time <= cfg_alarm_time;
        alarm_en <= cfg_alarm_en;
        periodic <= cfg_periodic;
      end
    end
  end
endmodule

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: NUM_CH independent timer channels with decoded alarm config writes
module multi_channel_timer import timer_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      sreset,
  input  logic [NUM_CH-1:0]         start,
  input  logic [NUM_CH-1:0]         capture,
  input  logic [NUM_CH-1:0]         rst_capture,
  input  logic                      cfg_we,
  input  logic [ch_idx_w(NUM_CH)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]          cfg_alarm_time,
  input  logic                      cfg_alarm_en,
  input  logic                      cfg_periodic,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic [NUM_CH*CNT_W-1:0]   capture_value,
  output logic [NUM_CH-1:0]         capture_valid,
  output logic [NUM_CH-1:0]         alarm,
  output logic [NUM_CH-1:0]         overflow
);
  localparam int CH_IDX_W = ch_idx_w(NUM_CH);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .sreset(sreset),
      .start(start[c]),
      .capture(capture[c]),
      .rst_capture(rst_capture[c]),
      .cfg_we(cfg_we && cfg_ch == CH_IDX_W'(c)),
      .cfg_alarm_time(cfg_alarm_time),
      .cfg_alarm_en(cfg_alarm_en),
      .cfg_periodic(cfg_periodic),
      .running(running[c]),
      .count(count[slice_lo(c, CNT_W) +: CNT_W]),
      .capture_value(capture_value[slice_lo(c, CNT_W) +: CNT_W]),
      .capture_valid(capture_valid[c]),
      .alarm(alarm[c]),
      .overflow(overflow[c])
    );
  end
endmodule
